// File: rtl/gearbox_row_fifo.sv
// gearbox_row_fifo: packs IN_W-bit words LSB-first into OUT_W-bit rows
// with a row address per row, valid/ready on both sides and start/abort/done.
module gearbox_row_fifo #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 72,
    parameter int BUF_W = 192,
    parameter int ROW_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [ROW_W-1:0] row_limit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [ROW_W-1:0] out_addr,
    output logic             busy,
    output logic             done
);

    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int OWED_W = ROW_W + $clog2(OUT_W + 1);

    localparam logic [FILL_W-1:0] C_IN   = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] C_OUT  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] C_ROOM = FILL_W'(BUF_W - IN_W);
    localparam logic [OWED_W-1:0] C_OWED_IN  = OWED_W'(IN_W);
    localparam logic [OWED_W-1:0] C_OWED_ROW = OWED_W'(OUT_W);
    localparam logic [ROW_W-1:0]  C_ONE = ROW_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAST
    } state_t;

    state_t            r_state;
    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic [OWED_W-1:0] r_owed;
    logic [ROW_W-1:0]  r_limit;
    logic [ROW_W-1:0]  r_rows;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic [ROW_W-1:0]  r_out_addr;
    logic              r_done;

    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_last_pop;
    logic [FILL_W-1:0] w_fill_sh;
    logic [FILL_W-1:0] w_fill_nx;
    logic [BUF_W-1:0]  w_buf_sh;
    logic [BUF_W-1:0]  w_word;
    logic [BUF_W-1:0]  w_buf_nx;
    logic [OWED_W-1:0] w_owed_nx;

    // Input is taken only while there is room for a whole word and the
    // transfer still needs bits; depends on registers only.
    assign w_in_ready = (r_state == S_RUN) && (r_fill <= C_ROOM)
                        && (r_owed != '0);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = (r_state == S_RUN) && (r_fill >= C_OUT)
                        && (!r_out_valid || out_ready);
    assign w_last_pop = w_pop && (r_rows == r_limit - C_ONE);

    // A pop shifts the buffer down first; the new word lands above what is left.
    assign w_fill_sh = w_pop ? r_fill - C_OUT : r_fill;
    assign w_buf_sh  = w_pop ? (r_buf >> OUT_W) : r_buf;
    assign w_word    = BUF_W'(in_data) << w_fill_sh;
    assign w_buf_nx  = w_push ? (w_buf_sh | w_word) : w_buf_sh;
    assign w_fill_nx = w_push ? w_fill_sh + C_IN : w_fill_sh;
    assign w_owed_nx = !w_push ? r_owed
                     : (r_owed > C_OWED_IN) ? r_owed - C_OWED_IN : '0;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    // Transfer control FSM with registered row output and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owed      <= '0;
            r_limit     <= '0;
            r_rows      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (row_limit != '0) begin
                                r_state <= S_RUN;
                                r_limit <= row_limit;
                                r_rows  <= '0;
                                r_owed  <= OWED_W'(row_limit) * C_OWED_ROW;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        r_owed <= w_owed_nx;
                        if (w_pop) begin
                            r_out_data  <= r_buf[OUT_W-1:0];
                            r_out_addr  <= r_rows;
                            r_out_valid <= 1'b1;
                            r_rows      <= r_rows + C_ONE;
                            if (w_last_pop) begin
                                r_state <= S_LAST;
                            end
                        end else if (r_out_valid && out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                    S_LAST: begin
                        if (r_out_valid && out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_IDLE;
                            r_done      <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Packing buffer; anything left over outside RUN is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else if (abort || (r_state != S_RUN)) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_buf_nx;
            r_fill <= w_fill_nx;
        end
    end

endmodule

// File: tb/tb_gearbox_row_fifo.sv
// tb_gearbox_row_fifo: directed checks on the 64->72 gearbox plus a
// random valid/ready stream check on a 32->48 instance.
module tb_gearbox_row_fifo;

    logic        clk;
    logic        rst;
    logic        start, abort;
    logic [6:0]  row_limit;
    logic        in_valid, in_ready;
    logic [63:0] in_data;
    logic        out_valid, out_ready;
    logic [71:0] out_data;
    logic [6:0]  out_addr;
    logic        busy, done;

    logic        start2, abort2;
    logic [6:0]  row_limit2;
    logic        in_valid2, in_ready2;
    logic [31:0] in_data2;
    logic        out_valid2, out_ready2;
    logic [47:0] out_data2;
    logic [6:0]  out_addr2;
    logic        busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_acc = 0, n_acc2 = 0;
    int done_cnt = 0, done_cnt2 = 0;
    int done_cyc = 0, last_acc = 0;
    logic [71:0] rq[$];
    logic [6:0]  aq[$];
    logic [47:0] rq2[$];
    logic [6:0]  aq2[$];

    gearbox_row_fifo dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .row_limit(row_limit), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    gearbox_row_fifo #(
        .IN_W(32), .OUT_W(48), .BUF_W(96), .ROW_W(7)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .row_limit(row_limit2), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_addr(out_addr2),
        .busy(busy2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] w64(input int k);
        logic [31:0] kk;
        kk = k;
        return {kk * 32'h9E3779B1, kk ^ 32'h5A5A0F0F};
    endfunction

    function automatic logic [31:0] w32(input int k);
        logic [31:0] kk;
        kk = k;
        return (kk * 32'h7FEB352D) ^ 32'hDEADBEEF;
    endfunction

    function automatic logic [71:0] erow64(input int b, input int r);
        logic [1279:0] s;
        for (int i = 0; i < 20; i++) s[i*64 +: 64] = w64(b + i);
        return s[r*72 +: 72];
    endfunction

    function automatic logic [47:0] erow32(input int b, input int r);
        logic [1023:0] s;
        for (int i = 0; i < 32; i++) s[i*32 +: 32] = w32(b + i);
        return s[r*48 +: 48];
    endfunction

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input int lim, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < lim) begin
            tick();
            n++;
        end
        check(tag, done_cnt > d0, 1);
    endtask

    task automatic wait_rows(input int k, input int lim, input string tag);
        int n;
        n = 0;
        while (aq.size() < k && n < lim) begin
            tick();
            n++;
        end
        check(tag, aq.size() >= k, 1);
    endtask

    task automatic check_rows(input string t, input int b, input int nr);
        check({t, "_nrows"}, rq.size(), nr);
        for (int i = 0; i < nr && i < rq.size(); i++) begin
            check($sformatf("%s_row%0d", t, i), rq[i], erow64(b, i));
            check($sformatf("%s_addr%0d", t, i), aq[i], i);
        end
    endtask

    // Handshake monitor: records what transfers at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (in_valid && in_ready) n_acc++;
                if (in_valid2 && in_ready2) n_acc2++;
                if (out_valid && out_ready) begin
                    rq.push_back(out_data);
                    aq.push_back(out_addr);
                    last_acc = cyc;
                end
                if (out_valid2 && out_ready2) begin
                    rq2.push_back(out_data2);
                    aq2.push_back(out_addr2);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (done2) done_cnt2++;
            end
        end
    end

    // Word source: always presents the next unconsumed word.
    initial begin
        in_data  = w64(0);
        in_data2 = w32(0);
        forever begin
            @(posedge clk);
            #1;
            in_data  = w64(n_acc);
            in_data2 = w32(n_acc2);
        end
    end

    initial begin
        int base, a0, d0, n;
        logic lo_seen;
        rst = 1'b1;
        start = 0; abort = 0; row_limit = 0;
        in_valid = 0; out_ready = 0;
        start2 = 0; abort2 = 0; row_limit2 = 0;
        in_valid2 = 0; out_ready2 = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_data_addr", {out_data, out_addr}, 0);

        // 1: eight rows at full rate
        in_valid = 1; out_ready = 1;
        rq.delete(); aq.delete();
        base = n_acc; a0 = n_acc; d0 = done_cnt;
        row_limit = 8; start = 1;
        tick();
        start = 0;
        wait_done(d0, 100, "t1_done_seen");
        repeat (3) tick();
        check("t1_words", n_acc - a0, 9);
        check_rows("t1", base, 8);
        check("t1_done_lat", done_cyc - last_acc, 1);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_idle", {busy, in_ready, out_valid}, 0);

        // 2: three rows, residual 40 bits dropped
        rq.delete(); aq.delete();
        base = n_acc; a0 = n_acc; d0 = done_cnt;
        row_limit = 3; start = 1;
        tick();
        start = 0;
        wait_done(d0, 100, "t2_done_seen");
        repeat (3) tick();
        check("t2_words", n_acc - a0, 4);
        check_rows("t2", base, 3);
        check("t2_idle", {busy, in_ready}, 0);

        // 3: output backpressure holds the row and stalls input
        rq.delete(); aq.delete();
        base = n_acc; a0 = n_acc; d0 = done_cnt;
        out_ready = 0; row_limit = 4; start = 1;
        tick();
        start = 0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("t3_valid_seen", out_valid, 1);
        lo_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold_data%0d", i), out_data, erow64(base, 0));
            check($sformatf("t3_hold_addr%0d", i), out_addr, 0);
            if (!in_ready) lo_seen = 1'b1;
            tick();
        end
        check("t3_in_ready_low", lo_seen, 1);
        out_ready = 1;
        wait_done(d0, 100, "t3_done_seen");
        repeat (2) tick();
        check("t3_words", n_acc - a0, 5);
        check_rows("t3", base, 4);

        // 4: abort mid-transfer, then a fresh single-row transfer
        rq.delete(); aq.delete();
        d0 = done_cnt;
        row_limit = 8; start = 1;
        tick();
        start = 0;
        wait_rows(3, 50, "t4_row2_seen");
        abort = 1;
        tick();
        abort = 0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_valid", out_valid, 0);
        repeat (4) tick();
        check("t4_no_done", done_cnt - d0, 0);
        rq.delete(); aq.delete();
        base = n_acc; a0 = n_acc; d0 = done_cnt;
        row_limit = 1; start = 1;
        tick();
        start = 0;
        wait_done(d0, 50, "t4_done_seen");
        repeat (2) tick();
        check("t4_words", n_acc - a0, 2);
        check_rows("t4", base, 1);

        // 5: zero-row start, then a start ignored during RUN
        d0 = done_cnt;
        row_limit = 0; start = 1;
        tick();
        start = 0;
        check("t5_zero_done", done, 1);
        check("t5_zero_busy", busy, 0);
        check("t5_zero_in_ready", in_ready, 0);
        tick();
        check("t5_zero_done_pulse", done, 0);
        rq.delete(); aq.delete();
        base = n_acc; d0 = done_cnt;
        row_limit = 4; start = 1;
        tick();
        start = 0;
        wait_rows(2, 50, "t5_row1_seen");
        row_limit = 2; start = 1;
        tick();
        start = 0;
        wait_done(d0, 100, "t5_done_seen");
        repeat (2) tick();
        check_rows("t5", base, 4);

        // 6a: asynchronous reset mid-transfer
        rq.delete(); aq.delete();
        d0 = done_cnt;
        row_limit = 8; start = 1;
        tick();
        start = 0;
        wait_rows(2, 50, "t6_row1_seen");
        rst = 1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_data_addr", {out_data, out_addr}, 0);
        tick();
        rst = 0;
        repeat (4) tick();
        check("t6_rst_no_done", done_cnt - d0, 0);
        check("t6_rst_idle", busy, 0);

        // 6b: random valid/ready on the 32->48 instance
        for (int t = 0; t < 2; t++) begin
            int lim, words;
            lim = (t == 0) ? 20 : 7;
            words = (t == 0) ? 30 : 11;
            rq2.delete(); aq2.delete();
            base = n_acc2; a0 = n_acc2; d0 = done_cnt2;
            row_limit2 = 7'(lim); start2 = 1;
            tick();
            start2 = 0;
            n = 0;
            while (done_cnt2 == d0 && n < 2000) begin
                in_valid2  = 1'($urandom_range(0, 1));
                out_ready2 = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            in_valid2 = 0; out_ready2 = 0;
            check($sformatf("r%0d_done_seen", t), done_cnt2 > d0, 1);
            tick();
            check($sformatf("r%0d_words", t), n_acc2 - a0, words);
            check($sformatf("r%0d_nrows", t), rq2.size(), lim);
            for (int i = 0; i < lim && i < rq2.size(); i++) begin
                check($sformatf("r%0d_row%0d", t, i), rq2[i],
                      erow32(base, i));
                check($sformatf("r%0d_addr%0d", t, i), aq2[i], i);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
